// File: rtl/ila_trigger_ctrl.sv
// Trigger qualification and capture sequencer feeding the ILA sample buffer write-qualify.
// Conditions probe bits (mask/negate/edge), combines them, and runs IDLE/ARMED/CAPTURE/DONE.
`ifndef ILA_MAX_SAMPLES_W
`define ILA_MAX_SAMPLES_W 16
`endif

module ila_trigger_ctrl #(
  parameter int TRIG_N = 4,
  parameter int CNT_W  = `ILA_MAX_SAMPLES_W,
  parameter int WAIT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_soft,
  input  logic [TRIG_N-1:0] trig_in,
  input  logic [TRIG_N-1:0] trig_mask,
  input  logic [TRIG_N-1:0] trig_negate,
  input  logic [TRIG_N-1:0] trig_edge,
  input  logic              combine_and,
  input  logic [CNT_W-1:0]  post_samples,
  input  logic              arm,
  input  logic              abort,
  output logic              capture,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state,
  output logic [WAIT_W-1:0] wait_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [TRIG_N-1:0] trig_q_r, trig_prev_r, cond_s;
  logic              hit_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [WAIT_W-1:0] wait_r, wait_s;
  logic              capture_r, busy_r, done_r;

  // Per-bit condition and AND/OR combine; an empty mask is a free-running trigger
  always_comb begin
    cond_s = (trig_edge & trig_q_r & ~trig_prev_r) | (~trig_edge & trig_q_r);
    if (trig_mask == {TRIG_N{1'b0}}) begin
      hit_s = 1'b1;
    end else if (combine_and) begin
      hit_s = &(cond_s | ~trig_mask);
    end else begin
      hit_s = |(cond_s & trig_mask);
    end
  end

  // Next-state, post-trigger counter and armed-wait counter; abort outranks everything
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    wait_s  = wait_r;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_s = ST_ARMED;
            cnt_s   = {CNT_W{1'b0}};
            wait_s  = {WAIT_W{1'b0}};
          end else begin
            state_s = state_r;
          end
        end
        ST_ARMED: begin
          if (hit_s) begin
            state_s = ST_CAPTURE;
          end else if (wait_r != WAIT_MAX) begin
            wait_s = wait_r + WAIT_ONE;
          end else begin
            wait_s = wait_r;
          end
        end
        ST_CAPTURE: begin
          // post_samples==0 means run until abort; the counter simply wraps
          cnt_s = cnt_r + CNT_ONE;
          if ((post_samples != {CNT_W{1'b0}}) && (cnt_r == post_samples - CNT_ONE)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CAPTURE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Input stage, state register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst || rst_soft) begin
      trig_q_r    <= {TRIG_N{1'b0}};
      trig_prev_r <= {TRIG_N{1'b0}};
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      wait_r      <= {WAIT_W{1'b0}};
      capture_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      trig_q_r    <= trig_in ^ trig_negate;
      trig_prev_r <= trig_q_r;
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      wait_r      <= wait_s;
      capture_r   <= (state_s == ST_CAPTURE);
      busy_r      <= (state_s == ST_ARMED) || (state_s == ST_CAPTURE);
      done_r      <= (state_s == ST_DONE);
    end
  end

  assign capture     = capture_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign state       = state_r;
  assign wait_cycles = wait_r;

endmodule

// File: tb/tb_ila_trigger_ctrl.sv
// Scoreboard bench for ila_trigger_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the trigger/capture rules.
module tb_ila_trigger_ctrl;

  localparam int TN   = 4;
  localparam int CW   = 8;
  localparam int WW   = 4;
  localparam int WMAX = 15;
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rst_soft, arm, abort, combine_and;
  logic [TN-1:0] trig_in, trig_mask, trig_negate, trig_edge;
  logic [CW-1:0] post_samples;
  logic          capture, busy, done;
  logic [1:0]    state;
  logic [WW-1:0] wait_cycles;

  ila_trigger_ctrl #(.TRIG_N(TN), .CNT_W(CW), .WAIT_W(WW)) dut (
    .clk(clk), .rst(rst), .rst_soft(rst_soft), .trig_in(trig_in),
    .trig_mask(trig_mask), .trig_negate(trig_negate), .trig_edge(trig_edge),
    .combine_and(combine_and), .post_samples(post_samples), .arm(arm), .abort(abort),
    .capture(capture), .busy(busy), .done(done), .state(state), .wait_cycles(wait_cycles)
  );

  typedef struct packed {
    logic [1:0]    st;
    logic          cap;
    logic          bsy;
    logic          dn;
    logic [WW-1:0] wc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  int            m_state, m_wait, m_cnt;
  logic [TN-1:0] m_q, m_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
  endtask

  // Reference model: apply the clock-edge rules to the inputs present at this edge
  task automatic model_step();
    int   nm, nmet;
    bit   hit;
    exp_t e;
    nm = 0;
    nmet = 0;
    for (int i = 0; i < TN; i++) begin
      if (trig_mask[i]) begin
        nm++;
        if (trig_edge[i] ? (m_q[i] && !m_prev[i]) : m_q[i]) nmet++;
      end
    end
    hit = (nm == 0) || (combine_and ? (nmet == nm) : (nmet > 0));
    if (rst || rst_soft) begin
      m_state = S_IDLE; m_wait = 0; m_cnt = 0; m_q = '0; m_prev = '0;
    end else begin
      m_prev = m_q;
      m_q    = trig_in ^ trig_negate;
      if (abort) m_state = S_IDLE;
      else begin
        case (m_state)
          S_IDLE, S_DONE: if (arm) begin m_state = S_ARMED; m_wait = 0; m_cnt = 0; end
          S_ARMED: if (hit) m_state = S_CAPTURE;
                   else m_wait = (m_wait + 1 > WMAX) ? WMAX : m_wait + 1;
          S_CAPTURE: begin
            if (post_samples != 0 && m_cnt == int'(post_samples) - 1) m_state = S_DONE;
            m_cnt = (m_cnt + 1) % (1 << CW);
          end
          default: m_state = S_IDLE;
        endcase
      end
    end
    e.st  = 2'(m_state);
    e.cap = (m_state == S_CAPTURE);
    e.bsy = (m_state == S_ARMED) || (m_state == S_CAPTURE);
    e.dn  = (m_state == S_DONE);
    e.wc  = WW'(m_wait);
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs just after each edge with the scoreboard entry
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("cycle_outputs", 32'({state, capture, busy, done, wait_cycles}), 32'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    arm = 1'b0;
    abort = 1'b0;
    rst_soft = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_count(input int n, output int ncap);
    ncap = 0;
    repeat (n) begin
      tick();
      if (capture) ncap++;
    end
  endtask

  int ncap;

  initial begin
    rst = 1'b1; rst_soft = 1'b0; arm = 1'b0; abort = 1'b0; combine_and = 1'b1;
    trig_in = 4'b0000; trig_mask = 4'b0001; trig_negate = 4'b0000; trig_edge = 4'b0000;
    post_samples = 8'd8;
    run(2);
    rst = 1'b0;
    check("reset", 32'({state, capture, busy, done, wait_cycles}), 32'd0);

    // Level trigger on bit 0, hit five edges after arming
    arm = 1'b1; tick();
    run(4);
    trig_in = 4'b0001;
    run_count(25, ncap);
    check("level_capture_len", 32'(ncap), 32'd8);
    check("level_wait_cycles", 32'(wait_cycles), 32'd5);
    check("level_done", 32'({done, state}), 32'({1'b1, 2'd3}));

    // Edge trigger on negated bit 1
    abort = 1'b1; tick();
    trig_mask = 4'b0010; trig_edge = 4'b0010; trig_negate = 4'b0010; combine_and = 1'b0;
    post_samples = 8'd3; trig_in = 4'b0010;
    run(2);
    arm = 1'b1; tick();
    run(3);
    check("edge_no_hit_high", 32'(state), 32'd1);
    trig_in = 4'b0000;
    run_count(8, ncap);
    check("edge_capture_len", 32'(ncap), 32'd3);
    arm = 1'b1; tick();
    run(10);
    check("edge_held_low", 32'(state), 32'd1);
    abort = 1'b1; tick();

    // AND versus OR combine
    trig_mask = 4'b0011; trig_edge = 4'b0000; trig_negate = 4'b0000; combine_and = 1'b1;
    post_samples = 8'd2; trig_in = 4'b0001;
    run(2);
    arm = 1'b1; tick();
    run(6);
    check("and_one_bit", 32'(state), 32'd1);
    trig_in = 4'b0011;
    run(2);
    check("and_both", 32'(state), 32'd2);
    run(5);
    combine_and = 1'b0; trig_in = 4'b0001;
    arm = 1'b1; tick();
    tick();
    check("or_one_bit", 32'(state), 32'd2);
    run(5);

    // Continuous capture, abort, arm+abort
    trig_mask = 4'b0000; post_samples = 8'd0;
    arm = 1'b1; tick();
    run_count(300, ncap);
    check("continuous_len", 32'(ncap), 32'd300);
    abort = 1'b1; tick();
    check("abort_out", 32'({capture, state}), 32'd0);
    arm = 1'b1; abort = 1'b1; tick();
    check("arm_abort", 32'(state), 32'd0);

    // Soft reset mid-capture, then re-arm from DONE
    post_samples = 8'd8;
    arm = 1'b1; tick();
    run(4);
    rst_soft = 1'b1; tick();
    check("soft_reset", 32'({state, capture, busy, done, wait_cycles}), 32'd0);
    arm = 1'b1; tick();
    run(12);
    check("shot_done", 32'(done), 32'd1);
    arm = 1'b1; tick();
    check("rearm", 32'({state, wait_cycles}), 32'({2'd1, 4'd0}));
    run(12);

    // Free-run trigger latency and wait saturation
    abort = 1'b1; tick();
    arm = 1'b1; tick();
    check("freerun_armed", 32'({state, capture}), 32'({2'd1, 1'b0}));
    tick();
    check("freerun_capture", 32'({capture, wait_cycles}), 32'({1'b1, 4'd0}));
    run(10);
    abort = 1'b1; tick();
    trig_mask = 4'b0001; trig_in = 4'b0000; post_samples = 8'd4;
    run(2);
    arm = 1'b1; tick();
    run(20);
    check("wait_saturate", 32'(wait_cycles), 32'd15);
    abort = 1'b1; tick();

    // Randomized traffic; configuration only changes while not busy
    for (int i = 0; i < 3000; i++) begin
      trig_in = TN'($urandom);
      if ((m_state == S_IDLE || m_state == S_DONE) && $urandom_range(0, 3) == 0) begin
        trig_mask    = TN'($urandom);
        trig_negate  = TN'($urandom);
        trig_edge    = TN'($urandom);
        combine_and  = 1'($urandom);
        post_samples = CW'($urandom_range(0, 6));
      end
      arm      = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 49) == 0);
      rst_soft = ($urandom_range(0, 299) == 0);
      tick();
    end

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
